aes_subbytes_serial: RTL and testbench
======================================

Name: aes_subbytes_serial

Overview:
Byte-serial AES SubBytes stage that feeds 128-bit states through NUM_SBOX instances of the team's combinational 8-bit `sbox` module.
- Accepts one state on a valid/ready input handshake.
- Substitutes NUM_SBOX bytes per clock.
- Presents the result on a valid/ready output handshake.

It sits between the round-key-add stage and ShiftRows. It trades throughput for area, since only NUM_SBOX S-boxes are instantiated instead of 16.

Parameters:
- NUM_SBOX, 1, S-box instances and bytes processed per cycle; legal values 1, 2, 4, 8, 16; any other value is a synthesis-time error.
- N_GROUPS, 16/NUM_SBOX, derived localparam (not overridable); processing cycles per state.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream state available.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  input state; byte i = in_state[127-8i -: 8] (FIPS-197 order, byte 0 in MSBs).
- out_valid  output  1  substituted state available.
- out_ready  input  1  downstream accepts.
- out_state  output  128  substituted state, same byte order.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset and clock:
  - One clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
  - While rst_n=0: FSM=IDLE, grp_cnt=0, state_reg=128'h0, out_valid=0, busy=0, in_ready=0 (in_ready is gated by rst_n).
  - out_state=128'h0 after reset.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: load state_reg<=in_state, grp_cnt<=0, go to RUN.
  - RUN:
    - in_ready=0, out_valid=0.
    - Each edge replaces bytes grp_cnt*NUM_SBOX .. grp_cnt*NUM_SBOX+NUM_SBOX-1 of state_reg with their sbox outputs, then grp_cnt<=grp_cnt+1.
    - On the edge processing grp_cnt==N_GROUPS-1: go to DONE and clear grp_cnt to 0.
  - DONE:
    - out_valid=1; out_state=state_reg, held stable until accepted.
    - in_ready=out_ready (combinational).
    - If out_ready and in_valid: load the new state and go to RUN (back-to-back, no bubble).
    - If out_ready and not in_valid: go to IDLE.
    - If not out_ready: stay in DONE, outputs unchanged.
- Latency: out_valid rises exactly N_GROUPS edges after the accepting edge (16 for NUM_SBOX=1, 1 for NUM_SBOX=16).
- Throughput:
  - Back-to-back with out_ready held high: one state per N_GROUPS+1 cycles.
  - Output handshake completes on any edge where out_valid and out_ready are both 1.
- grp_cnt width: clog2(N_GROUPS), minimum 1 bit.
- grp_cnt wraps only via the explicit clear on entry to DONE; it never free-runs.
- Boundary conditions:
  - in_valid while RUN: ignored, not latched; the source must hold it per handshake rules.
  - out_ready while not DONE: ignored.
  - Reset mid-RUN or mid-DONE: partial state discarded, out_valid drops immediately (asynchronous), FSM returns to IDLE.
  - out_state is driven by state_reg at all times; it is only meaningful while out_valid=1.
- The sbox mux select is grp_cnt only. No combinational path from in_state to out_state.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W=128, AES_BYTES=16, AES_BYTE_W=8.
  - FSM encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Byte-extract helper function get_byte(state, idx).
- Sub-modules:
  - No new sub-module.
  - Instantiate the existing `sbox` module NUM_SBOX times in a generate loop; input byte k is selected from state_reg by grp_cnt.

Test Plan:
- Reset state: assert rst_n=0 mid-RUN (after 5 edges, NUM_SBOX=1) -> out_valid=0 and busy=0 immediately. After release, in_ready=1 and out_state=0; the next accepted state processes correctly.
- All-zero state, NUM_SBOX=1: in_state=128'h0, out_ready=1 -> out_valid high exactly 16 edges after acceptance; out_state=128'h6363...63.
- FIPS-197 Appendix B, NUM_SBOX=1, 4, 16: in_state=128'h193de3bea0f4e22b9ac68d2ae9f84808 -> out_state=128'hd42711aee0bf98f1b8b45de51e415230; latency 16/4/1 edges respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_state=128'h00010203...0f -> out_state stays 128'h637c777bf26b6fc53001672bfed7ab76 and in_ready stays 0. Raise out_ready -> one transfer only.
- Back-to-back: in_valid held high with two states (all 8'h53, then all 8'hFF), out_ready=1 -> outputs all 8'hED then all 8'h16. The second state is accepted on the same edge the first completes; gap is N_GROUPS+1 cycles.
- in_valid asserted during RUN with a different value -> that value is not captured until the next IDLE or DONE acceptance; the first result is unaffected.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encodings and byte-extraction helper.
// Byte 0 of a state lives in the MSBs (FIPS-197 order).
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTES   = 16;
   localparam int AES_BYTE_W  = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic [AES_BYTE_W-1:0] get_byte(input logic [AES_STATE_W-1:0] state,
                                                      input logic [3:0] idx);
      return state[AES_STATE_W-1 - AES_BYTE_W*int'(idx) -: AES_BYTE_W];
   endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box: one byte in, substituted byte out.
// Pure lookup, no state, no handshake.
module sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the MSBs of the table.
   assign dout = TABLE[2047 - 8*int'(din) -: 8];

endmodule

// File: rtl/aes_subbytes_serial.sv
// Byte-serial AES SubBytes: NUM_SBOX bytes per cycle, result N_GROUPS edges after accept.
// Output held in DONE until out_ready; a new state may be accepted on the same edge.
module aes_subbytes_serial
   import aes_pkg::*;
#(
   parameter int NUM_SBOX = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int N_GROUPS = AES_BYTES / NUM_SBOX;
   localparam int CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

   generate
      if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
            NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
         $error("aes_subbytes_serial: NUM_SBOX must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      DONE = S_DONE
   } fsm_t;

   fsm_t                   fsm;
   logic [CNT_W-1:0]       grp_cnt;
   logic [AES_STATE_W-1:0] state_reg;
   logic [3:0]             base;
   logic [AES_BYTE_W-1:0]  sub_byte [NUM_SBOX];

   assign base = 4'(int'(grp_cnt) * NUM_SBOX);

   for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
      logic [3:0] idx;
      assign idx = base + 4'(k);
      sbox u_sbox (
         .din  (get_byte(state_reg, idx)),
         .dout (sub_byte[k])
      );
   end

   assign in_ready  = rst_n && ((fsm == IDLE) || ((fsm == DONE) && out_ready));
   assign out_state = state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         grp_cnt   <= '0;
         state_reg <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= in_state;
                  grp_cnt   <= '0;
                  fsm       <= RUN;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               for (int k = 0; k < NUM_SBOX; k++) begin
                  state_reg[AES_STATE_W-1 - AES_BYTE_W*(int'(base)+k) -: AES_BYTE_W] <= sub_byte[k];
               end
               if (grp_cnt == CNT_W'(N_GROUPS-1)) begin
                  grp_cnt   <= '0;
                  fsm       <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  grp_cnt <= grp_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  // Back-to-back accept keeps the pipeline free of bubbles.
                  if (in_valid) begin
                     state_reg <= in_state;
                     grp_cnt   <= '0;
                     fsm       <= RUN;
                  end else begin
                     fsm  <= IDLE;
                     busy <= 1'b0;
                  end
               end
            end
            default: begin
               fsm       <= IDLE;
               grp_cnt   <= '0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Scoreboard bench for aes_subbytes_serial at NUM_SBOX = 1, 4 and 16.
module tb_aes_subbytes_serial;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         iv   [3];
   logic         ir   [3];
   logic         ov   [3];
   logic         ordy [3];
   logic         bsy  [3];
   logic [127:0] ist  [3];
   logic [127:0] ost  [3];

   int ng [3] = '{16, 4, 1};
   int acc [3];
   logic prev_ov [3];
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   logic [127:0] q0 [$];
   logic [127:0] q1 [$];
   logic [127:0] q2 [$];

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_subbytes_serial #(.NUM_SBOX((g == 0) ? 1 : (g == 1) ? 4 : 16)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .in_state  (ist[g]),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .out_state (ost[g]),
         .busy      (bsy[g])
      );
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void qpush(input int l, input logic [127:0] d);
      case (l)
         0: q0.push_back(d);
         1: q1.push_back(d);
         default: q2.push_back(d);
      endcase
   endfunction

   function automatic int qsize(input int l);
      case (l)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [127:0] qpop(input int l);
      case (l)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Monitor: latency on out_valid rise, scoreboard compare on each output transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int l = 0; l < 3; l++) prev_ov[l] = 1'b0;
      end else begin
         for (int l = 0; l < 3; l++) begin
            if (ov[l] && !prev_ov[l]) chk($sformatf("latency_lane%0d", l), 128'(cyc - acc[l]), 128'(ng[l]));
            if (iv[l] && ir[l]) acc[l] = cyc + 1;
            if (ov[l] && ordy[l]) begin
               if (iv[l]) chk($sformatf("b2b_in_ready_lane%0d", l), 128'(ir[l]), 128'd1);
               if (qsize(l) == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output_lane%0d: got %h expected no transfer", l, ost[l]);
               end else begin
                  chk($sformatf("out_state_lane%0d", l), ost[l], qpop(l));
               end
            end
            prev_ov[l] = ov[l];
         end
      end
   end

   task automatic send(input int l, input logic [127:0] d, input logic [127:0] e, input bit push);
      int n = 0;
      bit ok = 1'b0;
      ist[l] = d;
      iv[l]  = 1'b1;
      if (push) qpush(l, e);
      while (!ok && n < 300) begin
         @(negedge clk);
         ok = ir[l];
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk($sformatf("accept_timeout_lane%0d", l), 128'd0, 128'd1);
      iv[l] = 1'b0;
   endtask

   initial begin
      int n;
      for (int l = 0; l < 3; l++) begin
         iv[l] = 1'b0; ordy[l] = 1'b1; ist[l] = '0; acc[l] = 0; prev_ov[l] = 1'b0;
      end
      #2;
      for (int l = 0; l < 3; l++) begin
         chk("reset_out_valid", 128'(ov[l]), 128'd0);
         chk("reset_busy", 128'(bsy[l]), 128'd0);
         chk("reset_in_ready", 128'(ir[l]), 128'd0);
         chk("reset_out_state", ost[l], 128'd0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset mid-RUN discards the partial state.
      send(0, FIPS_IN, 128'd0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("busy_in_run", 128'(bsy[0]), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_out_valid", 128'(ov[0]), 128'd0);
      chk("midrun_reset_busy", 128'(bsy[0]), 128'd0);
      chk("midrun_reset_in_ready", 128'(ir[0]), 128'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", 128'(ir[0]), 128'd1);
      chk("post_reset_out_state", ost[0], 128'd0);
      @(posedge clk);
      #1;

      send(0, 128'd0, {16{8'h63}}, 1'b1);
      send(0, FIPS_IN, FIPS_OUT, 1'b1);
      send(1, FIPS_IN, FIPS_OUT, 1'b1);
      send(2, FIPS_IN, FIPS_OUT, 1'b1);
      repeat (20) @(posedge clk);
      #1;

      // Backpressure: result must hold in DONE.
      ordy[0] = 1'b0;
      send(0, SEQ_IN, SEQ_OUT, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!ov[0] && n < 100);
      chk("bp_out_valid", 128'(ov[0]), 128'd1);
      repeat (10) begin
         chk("bp_hold_state", ost[0], SEQ_OUT);
         chk("bp_in_ready", 128'(ir[0]), 128'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 ordy[0] = 1'b1;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("bp_single_transfer", 128'(ov[0]), 128'd0);
      end
      @(posedge clk);
      #1;

      // Back-to-back with a differing in_valid presented during RUN.
      send(0, {16{8'h53}}, {16{8'hed}}, 1'b1);
      ist[0] = {16{8'hff}};
      iv[0]  = 1'b1;
      @(negedge clk);
      chk("run_in_ready", 128'(ir[0]), 128'd0);
      @(posedge clk);
      #1;
      send(0, {16{8'hff}}, {16{8'h16}}, 1'b1);

      n = 0;
      while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      for (int l = 0; l < 3; l++) chk($sformatf("drain_lane%0d", l), 128'(qsize(l)), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
